sfifo_asdp_ctrl: RTL and testbench
==================================

Name: sfifo_asdp_ctrl

Overview:
Single-clock first-word-fall-through FIFO controller that owns one external simple dual-port RAM instance.
- Drives the RAM's write port (wea/addra/dia) and its asynchronous read port (addrb/dob).
- Presents valid/ready streaming interfaces on both sides.
- Adds one registered output stage so the downstream path never sees the RAM's combinational read.
- Used as the standard buffering stage in front of datapath consumers.

Parameters:
DEPTH, 6, RAM address width; RAM holds 2**DEPTH words.
WIDTH, 32, data width.
AFULL, 2**DEPTH-4, level at or above which almost_full asserts (0 < AFULL <= 2**DEPTH+1).

Ports:
clk  in  1  single clock; all state updates on its rising edge.
srst  in  1  synchronous, active-high reset.
flush  in  1  synchronous clear of FIFO contents, same effect as srst on all state.
in_valid  in  1  write request.
in_ready  out  1  FIFO can accept; equals !mem_full.
in_data  in  WIDTH  write data.
out_valid  out  1  output register holds a word.
out_ready  in  1  consumer accepts the output word.
out_data  out  WIDTH  output register contents.
level  out  DEPTH+1  words held (RAM + output register).
almost_full  out  1  level >= AFULL (registered).
mem_wea  out  1  RAM write enable (combinational: in_valid & in_ready).
mem_addra  out  DEPTH  RAM write address = wptr[DEPTH-1:0].
mem_dia  out  WIDTH  RAM write data = in_data.
mem_addrb  out  DEPTH  RAM read address = rptr[DEPTH-1:0].
mem_dob  in  WIDTH  RAM asynchronous read data.

Behaviour:
- Clock/reset: clock port clk; reset port srst, synchronous, active-high. flush behaves identically. srst/flush take priority over any same-cycle transfer, and any transfer in that cycle is dropped.
- Reset values: wptr=rptr=0 (DEPTH+1 bits each), out_valid=0, out_data=0, level=0, almost_full=0. in_ready=1 from the first cycle after reset deasserts.
- Pointers: DEPTH+1 bits, wrap naturally modulo 2**(DEPTH+1).
  - mem_empty = (wptr==rptr).
  - mem_full = MSBs differ and low DEPTH bits equal.
- Write: when in_valid & in_ready, RAM written at that edge and wptr increments. While full, in_ready=0 and in_valid is ignored, with no side effects.
- Prefetch: load = !mem_empty & (!out_valid | out_ready). On load, out_data<=mem_dob, out_valid<=1, rptr increments.
  - Pop without load (out_valid & out_ready & mem_empty) sets out_valid<=0.
  - out_data holds its value when not loaded.
- Latency: word accepted in cycle N appears with out_valid=1 in cycle N+2 when the FIFO was empty. There is no write-to-output bypass.
- Throughput: one word/cycle sustained both sides. Simultaneous write and load in the same cycle is legal. A write into the slot being read is impossible: the read address only targets written entries.
- Full + out_ready: the pop frees RAM space at that edge; in_ready rises the next cycle. There is no combinational path from out_ready to in_ready.
- Level: registered; level <= level + push - pop, where push = in_valid&in_ready and pop = out_valid&out_ready. Maximum level is 2**DEPTH+1.
- almost_full is registered from the next-state level.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_valid hold.
- Underflow/overflow are impossible by construction.

Test Plan:
- Reset/idle: assert srst 2 cycles -> out_valid=0, level=0, in_ready=1, mem_wea=0, out_data=0.
- Latency: DEPTH=4; write 0xA5 in cycle 0 with out_ready=1 -> mem_wea=1, mem_addra=0 in cycle 0; out_valid=1, out_data=0xA5 in cycle 2; level returns to 0 in cycle 4.
- Fill: DEPTH=4, out_ready=0, write 0..19 continuously -> 17 accepted (0..16); in_ready=0 from cycle 17; level=17; almost_full once level>=12. Then drain with out_ready=1 -> out_data 0..16 in order, one per cycle, with no gaps.
- Streaming wrap: DEPTH=4, in_valid=1 and out_ready=1 for 100 cycles, incrementing data -> output equals input sequence delayed 2 cycles; pointers wrap with no loss or duplication; level stays at 1 or 2.
- Backpressure: random in_valid/out_ready at 50% for 10k cycles vs scoreboard model -> data order intact; out_data stable while stalled; level matches the model every cycle.
- Flush mid-operation: level=9 with in_valid=1 and out_ready=1, assert flush 1 cycle -> next cycle level=0, out_valid=0; the word offered during the flush cycle is dropped; the next write is read back first.

Source files
------------

// File: rtl/sfifo_asdp_ctrl.sv
// sfifo_asdp_ctrl: FWFT FIFO controller for an external simple dual-port RAM.
// Registered output stage hides the RAM's combinational read from the consumer.
module sfifo_asdp_ctrl #(
  parameter int DEPTH = 6,
  parameter int WIDTH = 32,
  parameter int AFULL = 2**DEPTH-4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [DEPTH:0]   level,
  output logic             almost_full,
  output logic             mem_wea,
  output logic [DEPTH-1:0] mem_addra,
  output logic [WIDTH-1:0] mem_dia,
  output logic [DEPTH-1:0] mem_addrb,
  input  logic [WIDTH-1:0] mem_dob
);
  localparam logic [DEPTH:0] ONE = (DEPTH+1)'(1);
  localparam logic [DEPTH:0] AF = (DEPTH+1)'(AFULL);
  logic [DEPTH:0] wptr, rptr, level_nxt;
  logic mem_empty, mem_full, push, pop, load;
  always_comb begin
    mem_empty = wptr == rptr;
    mem_full = (wptr[DEPTH] != rptr[DEPTH]) && (wptr[DEPTH-1:0] == rptr[DEPTH-1:0]);
    in_ready = !mem_full;
    push = in_valid && in_ready;
    pop = out_valid && out_ready;
    load = !mem_empty && (!out_valid || out_ready);
    level_nxt = level + (push ? ONE : '0) - (pop ? ONE : '0);
    mem_wea = push;
    mem_addra = wptr[DEPTH-1:0];
    mem_dia = in_data;
    mem_addrb = rptr[DEPTH-1:0];
  end
  // load also covers the pop case, so out_valid only drops when the RAM is empty
  always_ff @(posedge clk) begin
    if (srst || flush) begin
      wptr <= '0;
      rptr <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      level <= '0;
      almost_full <= 1'b0;
    end else begin
      if (push) wptr <= wptr + ONE;
      if (load) begin
        rptr <= rptr + ONE;
        out_data <= mem_dob;
      end
      out_valid <= load || (out_valid && !out_ready);
      level <= level_nxt;
      almost_full <= level_nxt >= AF;
    end
  end
endmodule

// File: tb/tb_sfifo_asdp_ctrl.sv
// tb_sfifo_asdp_ctrl: scoreboard bench for sfifo_asdp_ctrl with a behavioural RAM.
module tb_sfifo_asdp_ctrl;
  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int AFULL = 2**DEPTH-4;
  logic clk = 0, srst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, almost_full, mem_wea;
  logic [WIDTH-1:0] in_data = 0, out_data, mem_dia, mem_dob;
  logic [DEPTH:0] level;
  logic [DEPTH-1:0] mem_addra, mem_addrb;
  logic [WIDTH-1:0] ram [2**DEPTH];
  int checks = 0, fails = 0;
  sfifo_asdp_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AFULL(AFULL)) dut (
    .clk(clk), .srst(srst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .almost_full(almost_full), .mem_wea(mem_wea), .mem_addra(mem_addra),
    .mem_dia(mem_dia), .mem_addrb(mem_addrb), .mem_dob(mem_dob)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_wea) ram[mem_addra] <= mem_dia;
  assign mem_dob = ram[mem_addrb];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask
  // Scoreboard: q holds every word inside the FIFO, q[0] is the output register when ov.
  logic [WIDTH-1:0] q [$];
  bit ov = 0, armed = 0;
  int wcnt = 0;
  always @(negedge clk) begin
    int mem_cnt;
    bit rdy, pop, load, push;
    mem_cnt = q.size() - (ov ? 1 : 0);
    rdy = mem_cnt < 2**DEPTH;
    if (armed) begin
      chk("in_ready", 64'(in_ready), 64'(rdy));
      chk("level", 64'(level), 64'(q.size()));
      chk("out_valid", 64'(out_valid), 64'(ov));
      chk("almost_full", 64'(almost_full), 64'(q.size() >= AFULL));
      chk("mem_wea", 64'(mem_wea), 64'(in_valid && rdy));
      if (ov) chk("out_data", 64'(out_data), 64'(q[0]));
      if (in_valid && rdy) chk("mem_addra", 64'(mem_addra), 64'(wcnt % (2**DEPTH)));
    end
    if (srst || flush) begin
      q.delete();
      ov = 0;
      wcnt = 0;
      armed = 1;
    end else begin
      pop = ov && out_ready;
      load = mem_cnt > 0 && (!ov || out_ready);
      push = in_valid && rdy;
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(in_data);
        wcnt++;
      end
      ov = load ? 1'b1 : (pop ? 1'b0 : ov);
    end
  end
  task automatic set_in(input logic v, input logic [WIDTH-1:0] d, input logic r,
                        input logic f = 0, input logic s = 0);
    in_valid = v; in_data = d; out_ready = r; flush = f; srst = s;
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic r);
    set_in(v, d, r);
    tick();
  endtask
  initial begin
    set_in(0, 0, 0, 0, 1);
    tick();
    tick();
    set_in(0, 0, 0);
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_mem_wea", 64'(mem_wea), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    tick();
    set_in(1, 32'hA5, 1);
    #2;
    chk("lat_wea", 64'(mem_wea), 64'(1));
    chk("lat_addra", 64'(mem_addra), 64'(0));
    tick();
    cyc(0, 0, 1);
    set_in(0, 0, 1);
    #2;
    chk("lat_valid_c2", 64'(out_valid), 64'(1));
    chk("lat_data_c2", 64'(out_data), 64'(32'hA5));
    tick();
    cyc(0, 0, 1);
    set_in(0, 0, 1);
    #2;
    chk("lat_level_c4", 64'(level), 64'(0));
    tick();
    for (int i = 0; i < 20; i++) cyc(1, 32'(i), 0);
    set_in(0, 0, 0);
    #2;
    chk("fill_in_ready", 64'(in_ready), 64'(0));
    chk("fill_level", 64'(level), 64'(17));
    chk("fill_afull", 64'(almost_full), 64'(1));
    chk("fill_head", 64'(out_data), 64'(0));
    tick();
    for (int i = 0; i < 20; i++) cyc(0, 0, 1);
    for (int i = 0; i < 100; i++) cyc(1, 32'(1000 + i), 1);
    for (int i = 0; i < 20; i++) cyc(0, 0, 1);
    for (int i = 0; i < 10000; i++)
      cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 20; i++) cyc(0, 0, 1);
    for (int i = 0; i < 9; i++) cyc(1, 32'(500 + i), 0);
    set_in(0, 0, 0);
    #2;
    chk("pre_flush_level", 64'(level), 64'(9));
    set_in(1, 32'hDEAD, 1, 1);
    tick();
    set_in(1, 32'h1234, 1);
    #2;
    chk("flush_level", 64'(level), 64'(0));
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    tick();
    cyc(0, 0, 1);
    set_in(0, 0, 1);
    #2;
    chk("post_flush_valid", 64'(out_valid), 64'(1));
    chk("post_flush_data", 64'(out_data), 64'(32'h1234));
    tick();
    for (int i = 0; i < 5; i++) cyc(0, 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
